// File: rtl/risc_toy_mem_pkg.sv
// risc_toy_mem_pkg
//   Shared constants for the RISC_TOY memory responder and the core:
//   data-port direction encoding, the NOP/reset instruction word and the
//   opcode list used by RISC_TOY.
package risc_toy_mem_pkg;

   // DRW encoding on the data port (qualified by DREQ)
   localparam logic DRW_RD = 1'b0;
   localparam logic DRW_WR = 1'b1;

   // Instruction word driven after reset and for out-of-range fetches
   localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

   // Opcodes shared with RISC_TOY
   typedef enum logic [4:0] {
      OP_ADDI = 5'd0,  OP_ANDI = 5'd1,  OP_ORI  = 5'd2,  OP_MOVI = 5'd3,
      OP_ADD  = 5'd4,  OP_SUB  = 5'd5,  OP_NEG  = 5'd6,  OP_NOT  = 5'd7,
      OP_AND  = 5'd8,  OP_OR   = 5'd9,  OP_XOR  = 5'd10, OP_LSR  = 5'd11,
      OP_ASR  = 5'd12, OP_SHL  = 5'd13, OP_ROR  = 5'd14, OP_BR   = 5'd15,
      OP_BRL  = 5'd16, OP_J    = 5'd17, OP_JL   = 5'd18, OP_LD   = 5'd19,
      OP_LDR  = 5'd20, OP_ST   = 5'd21, OP_STR  = 5'd22
   } opcode_e;

endpackage

// File: rtl/risc_toy_mem_sat_cnt.sv
// risc_toy_mem_sat_cnt
//   Saturating up-counter: +1 per cycle with i_inc high, sticks at all-ones.
// Ports:
//   CLK    clock
//   RST    asynchronous active-high reset, clears the count
//   i_inc  increment request
//   o_cnt  current count
module risc_toy_mem_sat_cnt
   import risc_toy_mem_pkg::*;
#(
   parameter int CNTW = 32
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic            i_inc,
   output logic [CNTW-1:0] o_cnt
);

   logic [CNTW-1:0] r_cnt;
   logic            w_full;

   assign w_full = &r_cnt;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_cnt <= '0;
      end else if (i_inc && !w_full) begin
         r_cnt <= r_cnt + {{(CNTW-1){1'b0}}, 1'b1};
      end
   end

   assign o_cnt = r_cnt;

endmodule

// File: rtl/risc_toy_mem.sv
// risc_toy_mem
//   Word-addressed unified memory for RISC_TOY. Fetch and data ports give
//   registered reads with one cycle of latency (read-first against a
//   same-cycle write). Backdoor load port for preload, sticky out-of-range
//   error with first offending address, saturating access counters.
// Request semantics: a request is accepted on every rising edge where its
//   REQ is high; there is no back-pressure. Address/data are ignored while
//   REQ is low.
// Ports:
//   CLK, RST                   clock, async active-high reset
//   IREQ, IADDR -> INSTR       instruction fetch port
//   DREQ, DRW, DADDR, DWDATA   data port request (DRW 1=write)
//   DRDATA                     registered load data
//   LD_EN, LD_ADDR, LD_DATA    backdoor write (wins over a CPU write)
//   ERR, ERR_ADDR              sticky out-of-range flag and first address
//   CNT_IF, CNT_DRD, CNT_DWR   saturating accepted-request counters
module risc_toy_mem
   import risc_toy_mem_pkg::*;
#(
   parameter int AW   = 10,
   parameter int CNTW = 32
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic            IREQ,
   input  logic [29:0]     IADDR,
   output logic [31:0]     INSTR,
   input  logic            DREQ,
   input  logic            DRW,
   input  logic [29:0]     DADDR,
   input  logic [31:0]     DWDATA,
   output logic [31:0]     DRDATA,
   input  logic            LD_EN,
   input  logic [AW-1:0]   LD_ADDR,
   input  logic [31:0]     LD_DATA,
   output logic            ERR,
   output logic [29:0]     ERR_ADDR,
   output logic [CNTW-1:0] CNT_IF,
   output logic [CNTW-1:0] CNT_DRD,
   output logic [CNTW-1:0] CNT_DWR
);

   localparam int DEPTH = 1 << AW;

   logic [31:0] r_mem [DEPTH];
   logic [31:0] r_instr;
   logic [31:0] r_drdata;
   logic        r_err;
   logic [29:0] r_err_addr;

   logic w_if_inr, w_d_inr;
   logic w_rd_req, w_wr_req, w_wr_acc, w_wr_ok;
   logic w_if_oor, w_d_oor;

   assign w_if_inr = (IADDR[29:AW] == '0);
   assign w_d_inr  = (DADDR[29:AW] == '0);

   assign w_rd_req = DREQ && (DRW == DRW_RD);
   assign w_wr_req = DREQ && (DRW == DRW_WR);
   // A CPU write colliding with a backdoor write is discarded entirely:
   // no store, no count, no error.
   assign w_wr_acc = w_wr_req && !LD_EN;
   assign w_wr_ok  = w_wr_acc && w_d_inr;

   assign w_if_oor = IREQ && !w_if_inr;
   assign w_d_oor  = (w_rd_req || w_wr_acc) && !w_d_inr;

   // Storage has no reset so preloaded contents survive RST; writes are
   // blocked while RST is high.
   always_ff @(posedge CLK) begin
      if (!RST) begin
         if (LD_EN) begin
            r_mem[LD_ADDR] <= LD_DATA;
         end else if (w_wr_ok) begin
            r_mem[DADDR[AW-1:0]] <= DWDATA;
         end
      end
   end

   // Reads sample the array before this edge's write lands (read-first).
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_instr    <= NOP_INSTR;
         r_drdata   <= '0;
         r_err      <= 1'b0;
         r_err_addr <= '0;
      end else begin
         if (IREQ) begin
            r_instr <= w_if_inr ? r_mem[IADDR[AW-1:0]] : NOP_INSTR;
         end
         if (w_rd_req) begin
            r_drdata <= w_d_inr ? r_mem[DADDR[AW-1:0]] : '0;
         end
         // Data port wins the address capture when both ports fault at once.
         if (!r_err && (w_d_oor || w_if_oor)) begin
            r_err      <= 1'b1;
            r_err_addr <= w_d_oor ? DADDR : IADDR;
         end
      end
   end

   assign INSTR    = r_instr;
   assign DRDATA   = r_drdata;
   assign ERR      = r_err;
   assign ERR_ADDR = r_err_addr;

   risc_toy_mem_sat_cnt #(.CNTW(CNTW)) u_cnt_if (
      .CLK   (CLK),
      .RST   (RST),
      .i_inc (IREQ),
      .o_cnt (CNT_IF)
   );

   risc_toy_mem_sat_cnt #(.CNTW(CNTW)) u_cnt_drd (
      .CLK   (CLK),
      .RST   (RST),
      .i_inc (w_rd_req),
      .o_cnt (CNT_DRD)
   );

   risc_toy_mem_sat_cnt #(.CNTW(CNTW)) u_cnt_dwr (
      .CLK   (CLK),
      .RST   (RST),
      .i_inc (w_wr_acc),
      .o_cnt (CNT_DWR)
   );

endmodule

// File: tb/tb_risc_toy_mem.sv
// tb_risc_toy_mem
//   Directed table-driven bench for risc_toy_mem plus hand-written sequences
//   for reset, backdoor priority, dual-port faults and counter saturation.
module tb_risc_toy_mem;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        IREQ = 1'b0;
   logic [29:0] IADDR = '0;
   logic        DREQ = 1'b0;
   logic        DRW = 1'b0;
   logic [29:0] DADDR = '0;
   logic [31:0] DWDATA = '0;
   logic        LD_EN = 1'b0;
   logic [9:0]  LD_ADDR = '0;
   logic [31:0] LD_DATA = '0;
   logic [31:0] INSTR, DRDATA;
   logic        ERR;
   logic [29:0] ERR_ADDR;
   logic [31:0] CNT_IF, CNT_DRD, CNT_DWR;

   // second instance with narrow counters for saturation
   logic        ireq4 = 1'b0;
   logic [31:0] instr4, drdata4;
   logic        err4;
   logic [29:0] err_addr4;
   logic [3:0]  cnt_if4, cnt_drd4, cnt_dwr4;

   int checks = 0;
   int failures = 0;

   always #5 CLK = ~CLK;

   risc_toy_mem #(.AW(10), .CNTW(32)) u_dut (
      .CLK(CLK), .RST(RST),
      .IREQ(IREQ), .IADDR(IADDR), .INSTR(INSTR),
      .DREQ(DREQ), .DRW(DRW), .DADDR(DADDR), .DWDATA(DWDATA), .DRDATA(DRDATA),
      .LD_EN(LD_EN), .LD_ADDR(LD_ADDR), .LD_DATA(LD_DATA),
      .ERR(ERR), .ERR_ADDR(ERR_ADDR),
      .CNT_IF(CNT_IF), .CNT_DRD(CNT_DRD), .CNT_DWR(CNT_DWR)
   );

   risc_toy_mem #(.AW(10), .CNTW(4)) u_dut4 (
      .CLK(CLK), .RST(RST),
      .IREQ(ireq4), .IADDR(30'd0), .INSTR(instr4),
      .DREQ(1'b0), .DRW(1'b0), .DADDR(30'd0), .DWDATA(32'd0), .DRDATA(drdata4),
      .LD_EN(1'b0), .LD_ADDR(10'd0), .LD_DATA(32'd0),
      .ERR(err4), .ERR_ADDR(err_addr4),
      .CNT_IF(cnt_if4), .CNT_DRD(cnt_drd4), .CNT_DWR(cnt_dwr4)
   );

   typedef struct {
      logic        ld_en;
      logic [9:0]  ld_addr;
      logic [31:0] ld_data;
      logic        ireq;
      logic [29:0] iaddr;
      logic        dreq;
      logic        drw;
      logic [29:0] daddr;
      logic [31:0] dwdata;
      logic [31:0] e_instr;
      logic [31:0] e_drd;
      logic        e_err;
      logic [29:0] e_ea;
      logic [31:0] e_if;
      logic [31:0] e_rd;
      logic [31:0] e_wr;
   } vec_t;

   localparam int NV = 17;
   vec_t vecs [NV];

   function automatic vec_t mk(
      input logic ld_en, input logic [9:0] ld_addr, input logic [31:0] ld_data,
      input logic ireq, input logic [29:0] iaddr,
      input logic dreq, input logic drw, input logic [29:0] daddr, input logic [31:0] dwdata,
      input logic [31:0] e_instr, input logic [31:0] e_drd, input logic e_err,
      input logic [29:0] e_ea, input logic [31:0] e_if, input logic [31:0] e_rd,
      input logic [31:0] e_wr);
      vec_t v;
      v.ld_en = ld_en; v.ld_addr = ld_addr; v.ld_data = ld_data;
      v.ireq = ireq; v.iaddr = iaddr;
      v.dreq = dreq; v.drw = drw; v.daddr = daddr; v.dwdata = dwdata;
      v.e_instr = e_instr; v.e_drd = e_drd; v.e_err = e_err; v.e_ea = e_ea;
      v.e_if = e_if; v.e_rd = e_rd; v.e_wr = e_wr;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // advance to just after the next rising edge
   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle();
      LD_EN = 1'b0; LD_ADDR = '0; LD_DATA = '0;
      IREQ = 1'b0; IADDR = '0;
      DREQ = 1'b0; DRW = 1'b0; DADDR = '0; DWDATA = '0;
   endtask

   task automatic drive(input vec_t v);
      LD_EN = v.ld_en; LD_ADDR = v.ld_addr; LD_DATA = v.ld_data;
      IREQ = v.ireq; IADDR = v.iaddr;
      DREQ = v.dreq; DRW = v.drw; DADDR = v.daddr; DWDATA = v.dwdata;
   endtask

   task automatic check_all(input string tag, input logic [31:0] e_instr,
                            input logic [31:0] e_drd, input logic e_err,
                            input logic [29:0] e_ea, input logic [31:0] e_if,
                            input logic [31:0] e_rd, input logic [31:0] e_wr);
      check({tag, ".instr"},    INSTR,            e_instr);
      check({tag, ".drdata"},   DRDATA,           e_drd);
      check({tag, ".err"},      {31'd0, ERR},     {31'd0, e_err});
      check({tag, ".err_addr"}, {2'b0, ERR_ADDR}, {2'b0, e_ea});
      check({tag, ".cnt_if"},   CNT_IF,           e_if);
      check({tag, ".cnt_drd"},  CNT_DRD,          e_rd);
      check({tag, ".cnt_dwr"},  CNT_DWR,          e_wr);
   endtask

   initial begin
      //                ld ld_a  ld_data        ir iaddr       dr w daddr        dwdata        instr          drd            e  ea           if rd wr
      vecs[0]  = mk(1, 10'd5, 32'h1234_5678, 0, 30'd0,     0, 0, 30'd0,     32'h0,        32'h0,         32'h0,         0, 30'h0,   0, 0, 0);
      vecs[1]  = mk(1, 10'd0, 32'h0000_0055, 0, 30'd0,     0, 0, 30'd0,     32'h0,        32'h0,         32'h0,         0, 30'h0,   0, 0, 0);
      vecs[2]  = mk(1, 10'd3, 32'h0000_000A, 0, 30'd0,     0, 0, 30'd0,     32'h0,        32'h0,         32'h0,         0, 30'h0,   0, 0, 0);
      vecs[3]  = mk(0, 10'd0, 32'h0,         1, 30'd5,     0, 0, 30'd0,     32'h0,        32'h1234_5678, 32'h0,         0, 30'h0,   1, 0, 0);
      vecs[4]  = mk(0, 10'd0, 32'h0,         0, 30'd0,     1, 1, 30'd7,     32'hDEAD_BEEF, 32'h1234_5678, 32'h0,        0, 30'h0,   1, 0, 1);
      vecs[5]  = mk(0, 10'd0, 32'h0,         0, 30'd0,     1, 0, 30'd7,     32'h0,        32'h1234_5678, 32'hDEAD_BEEF, 0, 30'h0,   1, 1, 1);
      vecs[6]  = mk(0, 10'd0, 32'h0,         1, 30'd3,     1, 1, 30'd3,     32'h0000_000B, 32'h0000_000A, 32'hDEAD_BEEF, 0, 30'h0,  2, 1, 2);
      vecs[7]  = mk(0, 10'd0, 32'h0,         1, 30'd3,     0, 0, 30'd0,     32'h0,        32'h0000_000B, 32'hDEAD_BEEF, 0, 30'h0,   3, 1, 2);
      vecs[8]  = mk(0, 10'd0, 32'h0,         1, 30'd5,     1, 0, 30'd3,     32'h0,        32'h1234_5678, 32'h0000_000B, 0, 30'h0,   4, 2, 2);
      vecs[9]  = mk(0, 10'd0, 32'h0,         0, 30'd0,     1, 1, 30'h400,   32'h0000_00FF, 32'h1234_5678, 32'h0000_000B, 1, 30'h400, 4, 2, 3);
      vecs[10] = mk(0, 10'd0, 32'h0,         0, 30'd0,     1, 0, 30'h800,   32'h0,        32'h1234_5678, 32'h0,         1, 30'h400, 4, 3, 3);
      vecs[11] = mk(0, 10'd0, 32'h0,         1, 30'd0,     0, 0, 30'd0,     32'h0,        32'h0000_0055, 32'h0,         1, 30'h400, 5, 3, 3);
      vecs[12] = mk(0, 10'd0, 32'h0,         1, 30'h400,   0, 0, 30'd0,     32'h0,        32'h0,         32'h0,         1, 30'h400, 6, 3, 3);
      vecs[13] = mk(1, 10'd9, 32'h0000_0001, 0, 30'd0,     1, 1, 30'd9,     32'h0000_0002, 32'h0,        32'h0,         1, 30'h400, 6, 3, 3);
      vecs[14] = mk(0, 10'd0, 32'h0,         1, 30'd9,     1, 0, 30'd9,     32'h0,        32'h0000_0001, 32'h0000_0001, 1, 30'h400, 7, 4, 3);
      vecs[15] = mk(0, 10'd0, 32'h0,         1, 30'd7,     1, 1, 30'd7,     32'h0000_0011, 32'hDEAD_BEEF, 32'h0000_0001, 1, 30'h400, 8, 4, 4);
      vecs[16] = mk(0, 10'd0, 32'h0,         0, 30'd0,     1, 0, 30'd7,     32'h0,        32'hDEAD_BEEF, 32'h0000_0011, 1, 30'h400, 8, 5, 4);

      // clock/reset
      idle();
      RST = 1'b1;
      step();
      step();
      check_all("reset", 32'h0, 32'h0, 1'b0, 30'h0, 32'd0, 32'd0, 32'd0);
      check("reset.cnt_if4", {28'd0, cnt_if4}, 32'd0);
      RST = 1'b0;
      step();

      // table
      for (int i = 0; i < NV; i++) begin
         drive(vecs[i]);
         step();
         check_all($sformatf("vec%0d", i), vecs[i].e_instr, vecs[i].e_drd, vecs[i].e_err,
                   vecs[i].e_ea, vecs[i].e_if, vecs[i].e_rd, vecs[i].e_wr);
      end
      idle();

      // reset mid-fetch with a pending write to word 9
      IREQ = 1'b1; IADDR = 30'd9;
      DREQ = 1'b1; DRW = 1'b1; DADDR = 30'd9; DWDATA = 32'h0000_0003;
      #2;
      RST = 1'b1;
      #1;
      check_all("rst_async", 32'h0, 32'h0, 1'b0, 30'h0, 32'd0, 32'd0, 32'd0);
      step();
      check_all("rst_held", 32'h0, 32'h0, 1'b0, 30'h0, 32'd0, 32'd0, 32'd0);
      idle();
      RST = 1'b0;
      step();
      IREQ = 1'b1; IADDR = 30'd9;
      step();
      check_all("after_rst", 32'h0000_0001, 32'h0, 1'b0, 30'h0, 32'd1, 32'd0, 32'd0);
      idle();

      // backdoor beats an out-of-range CPU write: no flag, no count
      LD_EN = 1'b1; LD_ADDR = 10'd9; LD_DATA = 32'h0000_0002;
      DREQ = 1'b1; DRW = 1'b1; DADDR = 30'h400; DWDATA = 32'h0000_00FF;
      step();
      check_all("ld_prio", 32'h0000_0001, 32'h0, 1'b0, 30'h0, 32'd1, 32'd0, 32'd0);
      idle();
      IREQ = 1'b1; IADDR = 30'd9;
      step();
      check_all("ld_prio_rd", 32'h0000_0002, 32'h0, 1'b0, 30'h0, 32'd2, 32'd0, 32'd0);
      idle();

      // both ports out of range together: data address is captured
      IREQ = 1'b1; IADDR = 30'h1000;
      DREQ = 1'b1; DRW = 1'b0; DADDR = 30'h2000;
      step();
      check_all("dual_oor", 32'h0, 32'h0, 1'b1, 30'h2000, 32'd3, 32'd1, 32'd0);
      idle();
      IREQ = 1'b1; IADDR = 30'h3000;
      step();
      check_all("err_sticky", 32'h0, 32'h0, 1'b1, 30'h2000, 32'd4, 32'd1, 32'd0);
      idle();

      // saturation on the 4-bit counter instance
      for (int i = 1; i <= 20; i++) begin
         ireq4 = 1'b1;
         step();
         if (i == 14) check("sat.cnt14", {28'd0, cnt_if4}, 32'hE);
         if (i == 15) check("sat.cnt15", {28'd0, cnt_if4}, 32'hF);
      end
      ireq4 = 1'b0;
      check("sat.cnt20", {28'd0, cnt_if4}, 32'hF);
      check("sat.drd", {28'd0, cnt_drd4}, 32'h0);

      // report
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
